// File: rtl/link_pkg.sv
// link_pkg
// Shared definitions for the receive side of the inter-board byte link:
// handshake FSM state encoding, link byte width and timeout counter width.
package link_pkg;

  // Width of one byte carried on the parallel link lines.
  localparam int unsigned BYTE_W = 8;

  // Width of the ACK-state timeout counter.
  localparam int unsigned TMO_W = 8;

  // Receive handshake states.
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } link_state_e;

endpackage : link_pkg

// File: rtl/byte_fifo.sv
// byte_fifo
// Circular-buffer byte FIFO with power-of-two depth. Pointers wrap modulo
// DEPTH. A push while full or a pop while empty is ignored. A push and a
// pop in the same cycle advance both pointers and leave count unchanged.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset (empties the FIFO)
//   push   in   write din at the tail
//   din    in   byte to write
//   pop    in   remove the head entry
//   dout   out  head entry, combinational from registered state
//   count  out  current occupancy, 0..DEPTH
//   full   out  count == DEPTH
//   empty  out  count == 0
module byte_fifo
  import link_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [BYTE_W-1:0]       din,
  input  logic                    pop,
  output logic [BYTE_W-1:0]       dout,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy next state; DEPTH is a power of two so the
  // natural overflow of the pointer adders is the modulo-DEPTH wrap.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale contents are hidden by count/empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule : byte_fifo

// File: rtl/between_to_in.sv
// between_to_in
// Receive stage of the inter-board byte link. Captures {t0..t7} while the
// sender raises tsent, acknowledges with the level signal trecieve, queues
// bytes in a FIFO and exposes them on a valid/ready consumer port. A sender
// that never releases tsent raises the sticky err_timeout flag.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   t0..t7       in   link data lines, t0 is MSB
//   tsent        in   sender has valid data on the link
//   trecieve     out  byte accepted, held until tsent drops
//   dout         out  FIFO head byte
//   dvalid       out  FIFO not empty
//   dready       in   consumer pops head when dvalid is high
//   count        out  FIFO occupancy
//   err_timeout  out  sticky: tsent held in ACK for TIMEOUT cycles
module between_to_in
  import link_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    t0,
  input  logic                    t1,
  input  logic                    t2,
  input  logic                    t3,
  input  logic                    t4,
  input  logic                    t5,
  input  logic                    t6,
  input  logic                    t7,
  input  logic                    tsent,
  output logic                    trecieve,
  output logic [BYTE_W-1:0]       dout,
  output logic                    dvalid,
  input  logic                    dready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    err_timeout
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

  link_state_e      state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             capture;
  logic             fifo_full, fifo_empty;
  logic [BYTE_W-1:0] link_byte;

  assign link_byte = {t0, t1, t2, t3, t4, t5, t6, t7};

  // Handshake FSM and timeout counter. Capture only happens from IDLE, and
  // fullness comes from the registered count so a same-cycle pop cannot
  // open room for a capture.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (tsent && !fifo_full) begin
          capture = 1'b1;
          state_d = ACK;
          tmo_d   = '0;
        end
      end
      ACK: begin
        if (!tsent) begin
          state_d = IDLE;
        end else begin
          if (tmo_q != '1) tmo_d = tmo_q + TMO_W'(1);
          // Flag goes up on the same edge the counter lands on TIMEOUT.
          if (tmo_d == TMO_LIMIT) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign trecieve    = (state_q == ACK);
  assign err_timeout = err_q;
  assign dvalid      = !fifo_empty;

  byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .din   (link_byte),
    .pop   (dready && !fifo_empty),
    .dout  (dout),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule : between_to_in

// File: doc/between_to_in.md
# between_to_in

Receive-side stage of the inter-board byte link. It samples the eight parallel link lines `t0`..`t7` while the upstream sender raises `tsent`, and acknowledges each byte with `trecieve`. Captured bytes go into a small FIFO, which the local consumer drains through a valid/ready port. This block sits directly downstream of the transmit stage, on the same `clk`.

## Interface
- `DEPTH`, 4: FIFO depth in bytes; power of two, 2..16.
- `TIMEOUT`, 255: number of ACK-state cycles with `tsent` still high before `err_timeout` sets; 1..255.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `t0`..`t7`  in  1 each  link data lines; `t0` is MSB, `t7` is LSB. Valid only while `tsent`=1.
- `tsent`  in  1  sender has valid data on the link.
- `trecieve`  out  1  byte accepted; level signal held through the handshake.
- `dout`  out  8  FIFO head byte.
- `dvalid`  out  1  FIFO not empty.
- `dready`  in  1  consumer pops the head when `dvalid`=1.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `err_timeout`  out  1  sticky error flag: sender never released `tsent`.

## Operation
- The FSM has two states, IDLE and ACK. On reset it enters IDLE.
- IDLE:
  - If `tsent`=1 and the FIFO is not full (registered `count`<DEPTH), push `{t0..t7}`, set `trecieve`=1, and go to ACK.
  - If `tsent`=1 and the FIFO is full, stay in IDLE with `trecieve`=0. This is backpressure; capture happens on the first cycle with room.
- ACK:
  - Hold `trecieve`=1 and do not capture.
  - When `tsent`=0, clear `trecieve` and go to IDLE.
- Timeout counter:
  - 8 bits. Clears on entry to ACK and increments each ACK cycle while `tsent`=1, saturating.
  - When it reaches TIMEOUT, `err_timeout` sets. The state stays ACK.
  - `err_timeout` clears only on `rst`.
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo DEPTH.
  - A pop happens when `dvalid`&`dready`. A pop while empty is ignored.
  - Push and pop in the same cycle leave `count` unchanged, and both pointers advance.
  - Fullness for the capture decision uses the registered `count`. A pop in the same cycle does not enable a capture while full.
- `dout` reflects `mem[rd_ptr]` combinationally from registered state. It is don't-care while `dvalid`=0.
- Reset mid-handshake:
  - `rst` forces IDLE, `trecieve`=0, pointers and `count`=0, `err_timeout`=0. FIFO contents are lost.
  - If `tsent` is still high after reset, that byte is captured again.

## Timing
- Reset values: `trecieve`=0, `dvalid`=0, `count`=0, `err_timeout`=0, `dout`=don't-care.
- `tsent` is sampled high at edge E with room available:
  - `trecieve`=1 after E.
  - The byte is written at E, so `dvalid`=1 after E if the FIFO was empty.
- `tsent` is sampled low at edge F while in ACK: `trecieve`=0 after F. The next capture can happen at F+1 at the earliest.
- With a sender that drops `tsent` one cycle after seeing `trecieve` and restarts two cycles later, throughput is one byte per 4 cycles.
- Pop at edge P: `count` decrements and `dout` shows the next entry after P.
- `err_timeout` rises after the edge where the counter equals TIMEOUT, i.e. TIMEOUT cycles after entry to ACK.

## Structure
- Shared package `link_pkg`: FSM state encoding (IDLE=0, ACK=1), link byte width (8), and the timeout counter width (8).
- One sub-module, `byte_fifo` (parameter DEPTH). Ports: `clk`, `rst`, `push`, `din`, `pop`, `dout`, `count`, `full`, `empty`.
- Handshake FSM and timeout counter live in the top level.

## Test plan
- Single byte: reset, drive `{t0..t7}`=8'hA5 with `tsent`=1, drop `tsent` one cycle after `trecieve` rises. Require: `trecieve` high exactly one edge after `tsent`, then low; `dout`=8'hA5, `dvalid`=1, `count`=1; pop gives `count`=0.
- Backpressure: DEPTH=4, `dready`=0, send 8'h01..8'h05. Require: four acks; fifth `tsent` held with `trecieve`=0. One pop lets the fifth capture on the following edge; drain order is 01,02,03,04,05.
- Simultaneous push/pop: FIFO has 2 entries, capture and pop on the same edge. Require `count` stays 2, FIFO order preserved, pointers wrap correctly across 2×DEPTH bytes.
- Timeout: TIMEOUT=10, hold `tsent`=1 forever. Require: `err_timeout`=1 exactly 10 cycles after ACK entry, `trecieve` still 1. Dropping `tsent` returns to IDLE with `err_timeout` still 1.
- Reset mid-handshake: assert `rst` while in ACK with 3 bytes queued. Require: after the edge `trecieve`=0, `count`=0, `dvalid`=0, `err_timeout`=0; with `tsent` still high, recapture on the first edge after `rst` deasserts.
- Empty pop: `dready`=1 with FIFO empty for 5 cycles. Require `count` stays 0, no pointer movement, and the next byte reads back correctly.
